// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage in front of the instruction memory.
//
// Owns the program counter, presents it to the instruction memory, and
// captures the returned word into an IF/ID register that is handed to
// decode with a valid/ready handshake. Downstream redirects (branch, jump,
// jump-register) replace the PC and flush the single in-flight slot.
// An out-of-range or misaligned fetch address raises a sticky fault that
// stops all further fetching until reset.
//
// Ports:
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   pc           out  32  current fetch address to instruction memory
//   instr_in     in   32  instruction word for pc (same cycle)
//   if_valid     out  1   IF/ID register holds an instruction
//   if_ready     in   1   decode accepts IF/ID contents this cycle
//   if_instr     out  32  latched instruction
//   if_pc        out  32  address of if_instr
//   if_pc_plus4  out  32  if_pc + 4
//   redir_en     in   1   redirect request
//   redir_sel    in   2   00 branch, 01 jump, 10/11 jump-register
//   redir_pc4    in   32  pc+4 of the redirecting instruction
//   redir_imm    in   26  branch offset [15:0] / jump index [25:0]
//   redir_reg    in   32  jump-register target
//   fault        out  1   sticky fetch fault
//   fault_pc     out  32  address that caused the fault
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    input  logic        redir_en,
    input  logic [1:0]  redir_sel,
    input  logic [31:0] redir_pc4,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    // Redirect target. Branch offsets are word offsets, so the sign-extended
    // 16-bit immediate is shifted left by two before the wrap-around add.
    function automatic logic [31:0] redirect_target(
        input logic [1:0]  sel,
        input logic [31:0] pc4,
        input logic [25:0] imm,
        input logic [31:0] reg_tgt
    );
        logic signed [31:0] offset;
        offset = {{14{imm[15]}}, imm[15:0], 2'b00};
        case (sel)
            2'b00:   return pc4 + $unsigned(offset);
            2'b01:   return {pc4[31:28], imm, 2'b00};
            default: return reg_tgt;   // 11 behaves as jump-register
        endcase
    endfunction

    // Fetch stage (p0): program counter and fault state
    logic [31:0] pc_p0;
    logic        fault_p0;
    logic [31:0] fault_pc_p0;

    // IF/ID register (p1)
    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc4_p1;

    logic [31:0] target;
    logic        can_load;
    logic        out_of_range;

    assign target       = redirect_target(redir_sel, redir_pc4, redir_imm, redir_reg);
    assign can_load     = !vld_p1 || if_ready;
    assign out_of_range = (pc_p0[31:2] >= IMEM_LIMIT);

    // Priority: reset, redirect, sticky fault, range fault, load, stall.
    // A redirect flushes the slot even when decode is taking it this cycle:
    // decode still consumes that entry, only the next fetch is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            fault_p0    <= 1'b0;
            fault_pc_p0 <= 32'h0;
            vld_p1      <= 1'b0;
            instr_p1    <= 32'h0;
            pc_p1       <= 32'h0;
            pc4_p1      <= 32'h0;
        end else if (redir_en) begin
            vld_p1 <= 1'b0;
            pc_p0  <= target;
            // Only the first fault is recorded; later ones leave fault_pc alone.
            if ((target[1:0] != 2'b00) && !fault_p0) begin
                fault_p0    <= 1'b1;
                fault_pc_p0 <= target;
            end
        end else if (fault_p0) begin
            // Faulted: let decode drain the held entry, never fetch again.
            if (vld_p1 && if_ready) begin
                vld_p1 <= 1'b0;
            end
        end else if (can_load && out_of_range) begin
            fault_p0    <= 1'b1;
            fault_pc_p0 <= pc_p0;
            vld_p1      <= 1'b0;
        end else if (can_load) begin
            // p0 -> p1: capture the memory word alongside its address
            vld_p1   <= 1'b1;
            instr_p1 <= instr_in;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc_p0 + 32'd4;
            pc_p0    <= pc_p0 + 32'd4;
        end
    end

    assign pc          = pc_p0;
    assign fault       = fault_p0;
    assign fault_pc    = fault_pc_p0;
    assign if_valid    = vld_p1;
    assign if_instr    = instr_p1;
    assign if_pc       = pc_p1;
    assign if_pc_plus4 = pc4_p1;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives it onto the memory's `pc` input. It captures the returned instruction into an IF/ID register with a valid/ready handshake toward decode, and applies branch, jump and jump-register redirects from downstream with a one-slot flush. It raises a sticky fault on an out-of-range or misaligned fetch address.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `IMEM_WORDS`, default 32: number of words in the instruction memory; valid word indices are 0..IMEM_WORDS-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  out  32  current fetch address, driven to the instruction memory.
- `instr_in`  in  32  instruction returned by the memory for `pc`; valid in the same cycle.
- `if_valid`  out  1  IF/ID register holds an instruction.
- `if_ready`  in  1  decode accepts the IF/ID contents this cycle.
- `if_instr`  out  32  latched instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc` + 4.
- `redir_en`  in  1  redirect request this cycle.
- `redir_sel`  in  2  redirect type: 00 branch, 01 jump, 10 jump-register, 11 reserved (treated as 10).
- `redir_pc4`  in  32  pc+4 of the redirecting instruction.
- `redir_imm`  in  26  branch uses [15:0]; jump uses [25:0].
- `redir_reg`  in  32  register target for jump-register.
- `fault`  out  1  sticky fetch fault.
- `fault_pc`  out  32  offending address.

## Operation
- **Target computation**, combinational, 32-bit wrap-around arithmetic:
  - Branch: `redir_pc4` + (sign-extended `redir_imm[15:0]` << 2).
  - Jump: {`redir_pc4[31:28]`, `redir_imm`, 2'b00}.
  - Jump-register: `redir_reg`.
- **Define** `can_load` = !`if_valid` || `if_ready`.
- **Per-cycle priority:**
  1. **reset**: `pc`=RESET_PC; `if_valid`=0; `if_instr`=`if_pc`=`if_pc_plus4`=0; `fault`=0; `fault_pc`=0.
  2. **redir_en**: `if_valid`<=0 (flush, regardless of `if_ready`); `pc`<=target. If target[1:0]≠0 and `fault`=0, then `fault`<=1 and `fault_pc`<=target.
  3. **fault set**: no fetch. If `if_valid` && `if_ready`, then `if_valid`<=0; `pc` holds.
  4. **can_load with pc[31:2] ≥ IMEM_WORDS**: `fault`<=1, `fault_pc`<=`pc`, `if_valid`<=0, `pc` holds.
  5. **can_load**: `if_valid`<=1, `if_instr`<=`instr_in`, `if_pc`<=`pc`, `if_pc_plus4`<=`pc`+4, `pc`<=`pc`+4.
  6. **otherwise (stall)**: all state holds.
- **Fault** is cleared only by reset. Redirects still update `pc` while faulted, but nothing is fetched.
- **PC wrap**: `pc`+4 wraps at 2^32, with no special handling. In practice, the range check faults first.
- The IF/ID payload changes only on a load, on reset, or through the flush of `if_valid`; payload bits are not cleared on flush.

## Timing
- Fetch latency: one cycle from `pc` to `if_valid`/`if_instr`.
- Throughput: one instruction per cycle while `if_ready`=1.
- **Handshake:**
  - A transfer occurs on an edge where `if_valid` && `if_ready`.
  - While `if_valid`=1 && `if_ready`=0, `if_instr`, `if_pc` and `if_pc_plus4` are stable and `pc` holds.
- **Redirect:**
  - `pc` = target in the next cycle.
  - The first instruction from the target is valid 2 cycles after `redir_en` is sampled.
  - Exactly one wrong-path slot is dropped.
- **Simultaneous events:**
  - `redir_en` with `if_valid` && `if_ready`: decode consumes the current entry, and the new fetch is suppressed.
  - `redir_en` with `reset`: reset wins.
- **Reset mid-stall or mid-fault**: all outputs return to reset values on the next edge.
- `fault` asserts on the edge after the offending `pc` or target is sampled.

## Test plan
- **Sequential fetch**: reset, `if_ready`=1, memory word i = 32'h1000_0000+i. Required: `if_valid`=1 from cycle 1, `if_pc` = 0, 4, 8…, `if_instr` matches each address, `if_pc_plus4` = `if_pc`+4.
- **Stall**: drop `if_ready` for 3 cycles with `if_pc`=8. Required: `if_pc`=8 and `pc`=12 hold for 3 cycles; the next transfer after release is `if_pc`=12.
- **Branch redirect**: `redir_sel`=00, `redir_pc4`=16, `redir_imm`=16'hFFFE. Required: `pc`=8 next cycle; the wrong-path slot is dropped (`if_valid`=0 one cycle); then `if_pc`=8.
- **Jump and jump-register**:
  - jump with `redir_pc4`=32'h0000_0010, `redir_imm`=26'h3: requires `pc`=12.
  - jump-register with `redir_reg`=32'h14: requires `pc`=20.
- **Range fault**: with IMEM_WORDS=32, fetch sequentially to `pc`=128. Required: `fault`=1, `fault_pc`=128, no further `if_valid` after the word-31 entry is consumed, `pc` holds at 128.
- **Misaligned jump-register and reset recovery**: `redir_reg`=32'h6. Required: `fault`=1, `fault_pc`=6, then reset returns `pc`=0, `fault`=0, `if_valid`=0.
